uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver that fills the terminal's uart_rx byte and uart_rx_done flag (terminal addresses 3 and 4) from a physical RXD pin, replacing the hard-wired test values.
- Frame format: 8N1, LSB first. Sampling is single-point at mid-bit, timed by a bit-period counter.
- Presents a received byte, a one-cycle done strobe, and a sticky valid flag that the CPU clears through the terminal.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal range ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2, offset from start-bit edge to the start-bit sample point.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rxd  input  1  serial line, asynchronous to clk, idles high
- rx_clear  input  1  one-cycle pulse; clears rx_valid, frame_err, overrun_err (terminal write of 0 to addr 4)
- rx_data  output  8  last good received byte
- rx_done  output  1  one-cycle pulse when rx_data updates
- rx_valid  output  1  sticky "byte available" flag (maps to uart_rx_done_flag)
- frame_err  output  1  sticky, stop bit sampled low
- overrun_err  output  1  sticky, new byte completed while rx_valid=1
- busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: rx_data=8'h00, all flags and rx_done=0, busy=0, state=IDLE. Synchronizer flops reset to 1 so no false start bit is detected.
- rxd passes through a 2-FF synchronizer. All logic uses the synced value rs and its previous value rs_d.
- IDLE: on rs_d=1 and rs=0 (falling edge), clear the bit counter, go to START.
- START: count HALF_BIT-1 cycles, then sample.
  - rs=1: glitch; return to IDLE with no flags changed.
  - rs=0: go to DATA with bit index 0.
- DATA: every CLKS_PER_BIT cycles, sample rs into shift[idx], LSB first. After idx 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rs.
  - rs=1: rx_data<=shift, rx_done=1 for one cycle, rx_valid<=1. If rx_valid was already 1, also set overrun_err (data is overwritten).
  - rs=0: set frame_err; rx_data, rx_done and rx_valid are untouched. Go to WAIT_IDLE.
  - Good stop bit: go to IDLE immediately. The next falling edge may start a new frame at once (back-to-back frames).
- WAIT_IDLE: hold until rs=1, then go to IDLE. This prevents a break or stuck-low line from producing repeated frames.
- Latency: rx_done rises 2 (synchronizer) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the rxd falling edge, ±1 cycle.
- rx_clear coinciding with a completion or error in the same cycle: the set wins. The flag stays (or becomes) 1; rx_clear affects only flags not being set that cycle.
- rx_clear while busy: clears flags only; the frame in progress continues unaffected.
- Counters: bit-period counter sized $clog2(CLKS_PER_BIT), bit index 3 bits. No wrap beyond terminal counts; each counter reloads to 0 on its terminal count.
- Reset asserted mid-frame: immediate return to the reset state. The partial byte is discarded and nothing is emitted.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit after CLKS_PER_BIT cycles.
  - Extra output parity_err (1 bit, sticky, reset 0, cleared by rx_clear).
  - On mismatch, set parity_err and suppress the rx_data update, rx_done and rx_valid. The stop-bit check still runs.
  - Latency grows by CLKS_PER_BIT.
- Not defined: 8N1 only; the parity_err port does not exist.

Test Plan:
- CLKS_PER_BIT=8: drive frame for 8'hA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> rx_data=8'hA5, rx_done pulses exactly once at edge-relative cycle 2+4+72+1 (±1), rx_valid=1, no errors.
- Glitch: rxd low for 2 cycles then high -> busy returns 0 after the START sample, rx_done never asserts, all flags remain 0.
- Framing: send 8'h3C with stop=0 -> frame_err=1, rx_valid=0, rx_data keeps its prior value. While rxd is held low, no new frame starts until rxd returns high.
- Overrun: send 8'h11 then 8'h22 back-to-back without rx_clear -> rx_data=8'h22, overrun_err=1, rx_valid=1. Then pulse rx_clear -> all flags 0.
- Simultaneous: pulse rx_clear in the exact cycle rx_done fires for 8'h7E -> rx_valid=1 after that edge.
- Reset mid-frame: assert reset during DATA bit 4 of 8'hFF, release, then send 8'h81 -> only 8'h81 is received, rx_done pulses once, no errors. With UART_RX_PARITY_EN, 8'h81 sent with a wrong parity bit of 1 -> parity_err=1 and rx_valid=0.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first, with single-point mid-bit
//               sampling timed by a bit-period counter. rxd is brought into
//               the clk domain through a 2-FF synchronizer. It presents the
//               last good byte, a one-cycle done strobe and sticky status
//               flags that rx_clear clears.
// Optional    : `define UART_RX_PARITY_EN adds one even-parity bit between
//               the data bits and the stop bit. It also adds the sticky
//               parity_err output.
// Ports       : clk         - system clock, rising edge
//               reset       - asynchronous, active-high reset
//               rxd         - serial line, asynchronous, idles high
//               rx_clear    - pulse; clears rx_valid and the error flags
//               rx_data     - last good received byte
//               rx_done     - one-cycle pulse in the cycle rx_data is loaded
//               rx_valid    - sticky byte-available flag
//               frame_err   - sticky, stop bit sampled low
//               overrun_err - sticky, byte completed while rx_valid was set
//               parity_err  - sticky, parity mismatch (parity build only)
//               busy        - receiver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_clear,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(HALF_BIT - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_S_STOP   = 3'd4;
    localparam logic [2:0] c_S_WAIT   = 3'd5;

    // Synchronizer and edge-detect history. These flops reset high so that
    // leaving reset never looks like a falling edge on the line.
    logic r_sync_meta;
    logic r_rs;
    logic r_rs_d;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_overrun_err;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         w_idx_nxt;
    logic               w_bit_term;
    logic               w_shift_we;
    logic               w_good;
    logic               w_stop_bad;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    logic w_par_set;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= 1'b1;
            r_rs        <= 1'b1;
            r_rs_d      <= 1'b1;
        end else begin
            r_sync_meta <= rxd;
            r_rs        <= r_sync_meta;
            r_rs_d      <= r_rs;
        end
    end

    assign w_bit_term = (r_cnt == c_BIT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_we  = 1'b0;
        w_good      = 1'b0;
        w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_set   = 1'b0;
`endif
        case (r_state)
            c_S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (r_rs_d && !r_rs) begin
                    w_state_nxt = c_S_START;
                end
            end
            c_S_START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    // A line already back high at mid start bit is a glitch.
                    w_state_nxt = r_rs ? c_S_IDLE : c_S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_S_DATA: begin
                if (w_bit_term) begin
                    w_cnt_nxt  = '0;
                    w_shift_we = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = c_S_PARITY;
`else
                        w_state_nxt = c_S_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            c_S_PARITY: begin
                if (w_bit_term) begin
                    w_cnt_nxt   = '0;
                    // Even parity: the parity bit equals the XOR of the data.
                    w_par_set   = (r_rs != ^r_shift);
                    w_state_nxt = c_S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
`endif
            c_S_STOP: begin
                if (w_bit_term) begin
                    w_cnt_nxt = '0;
                    if (r_rs) begin
`ifdef UART_RX_PARITY_EN
                        w_good = !r_par_bad;
`else
                        w_good = 1'b1;
`endif
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        // Wait for the line to return high so a break does not
                        // produce a stream of bogus frames.
                        w_stop_bad  = 1'b1;
                        w_state_nxt = c_S_WAIT;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_S_WAIT: begin
                w_cnt_nxt = '0;
                if (r_rs) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_rx_data <= '0;
        end else begin
            if (w_shift_we) begin
                r_shift[r_idx] <= r_rs;
            end
            if (w_good) begin
                r_rx_data <= r_shift;
            end
        end
    end

    // Sticky flags: a set in the same cycle as rx_clear takes precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_rx_valid    <= w_good | (r_rx_valid & ~rx_clear);
            r_frame_err   <= w_stop_bad | (r_frame_err & ~rx_clear);
            r_overrun_err <= (w_good & r_rx_valid) | (r_overrun_err & ~rx_clear);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == c_S_PARITY && w_bit_term) begin
                r_par_bad <= w_par_set;
            end
            r_parity_err <= w_par_set | (r_parity_err & ~rx_clear);
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign rx_data     = r_rx_data;
    assign rx_done     = w_good;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = (r_state != c_S_IDLE);

endmodule
`default_nettype wire
